// File: rtl/lfsr_stream_ctrl.sv
// lfsr_stream_ctrl: sequences an external LFSR (seed load, N shifts per word)
// and streams the sampled LFSR state out over a valid/ready interface.
// Optional feature macro: LFSR_STREAM_CTRL_ZERO_SEED_GUARD_EN -- when defined,
// an all-zero seed is replaced by 1 so a lock-up-prone LFSR still runs.
module lfsr_stream_ctrl #(
  parameter int DATA_W          = 32,
  parameter int CNT_W           = 16,
  parameter int SHIFTS_PER_WORD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed_in,
  input  logic [CNT_W-1:0]  num_words,
  output logic              lfsr_set,
  output logic              lfsr_shift,
  output logic [DATA_W-1:0] lfsr_seed,
  input  logic [DATA_W-1:0] lfsr_state,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CAPT  = 3'd3,
    OUT   = 3'd4,
    FIN   = 3'd5
  } state_t;

  // Last value of the 8-bit shift counter before moving on to capture.
  localparam logic [7:0] SHIFT_LAST = 8'(SHIFTS_PER_WORD - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] seed_reg;
  logic [DATA_W-1:0] seed_guarded;
  logic [DATA_W-1:0] m_data_reg;
  logic [CNT_W-1:0]  num_words_reg;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic [CNT_W-1:0]  word_cnt_inc;
  logic [7:0]        shift_cnt_reg;
  logic              start_accept;
  logic              handshake;

`ifdef LFSR_STREAM_CTRL_ZERO_SEED_GUARD_EN
  // An all-zero seed would freeze the LFSR; substitute the smallest nonzero seed.
  assign seed_guarded = (seed_in == '0) ? DATA_W'(1) : seed_in;
`else
  assign seed_guarded = seed_in;
`endif

  assign start_accept = (state_reg == IDLE) && start;
  assign handshake    = (state_reg == OUT) && m_ready;
  // Increment stays within CNT_W: it is only used while word_cnt < num_words.
  assign word_cnt_inc = word_cnt_reg + CNT_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (num_words == '0) ? FIN : LOAD;
        end
      end
      LOAD:  state_next = SHIFT;
      SHIFT: begin
        if (shift_cnt_reg == SHIFT_LAST) begin
          state_next = CAPT;
        end
      end
      CAPT:  state_next = OUT;
      OUT: begin
        if (m_ready) begin
          state_next = (word_cnt_inc == num_words_reg) ? FIN : SHIFT;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Run parameters, shift pacing, captured word and progress counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_reg      <= '0;
      num_words_reg <= '0;
      word_cnt_reg  <= '0;
      m_data_reg    <= '0;
      shift_cnt_reg <= '0;
    end else begin
      if (start_accept) begin
        seed_reg      <= seed_guarded;
        num_words_reg <= num_words;
        word_cnt_reg  <= '0;
      end
      if ((state_reg == SHIFT) && (state_next == SHIFT)) begin
        shift_cnt_reg <= shift_cnt_reg + 8'd1;
      end else begin
        shift_cnt_reg <= '0;
      end
      if (state_reg == CAPT) begin
        m_data_reg <= lfsr_state;
      end
      if (handshake) begin
        word_cnt_reg <= word_cnt_inc;
      end
    end
  end

  assign lfsr_set   = (state_reg == LOAD);
  assign lfsr_shift = (state_reg == SHIFT);
  assign lfsr_seed  = seed_reg;
  assign m_data     = m_data_reg;
  assign m_valid    = (state_reg == OUT);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == FIN);
  assign word_cnt   = word_cnt_reg;

endmodule

// File: tb/tb_lfsr_stream_ctrl.sv
// Testbench for lfsr_stream_ctrl: two instances (1 and 4 shifts per word),
// each driving a Fibonacci LFSR with poly 0x8020_0003; a scoreboard queue per
// instance holds expected words and expected final counts at done.
module tb_lfsr_stream_ctrl;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] seed_in = '0;
  logic [CW-1:0] num_words = '0;
  logic          m_ready = 1'b1;

  logic          start_a = 1'b0, set_a, shift_a, valid_a, busy_a, done_a;
  logic [DW-1:0] seed_a, data_a, lstate_a = '0;
  logic [CW-1:0] cnt_a;
  logic          start_b = 1'b0, set_b, shift_b, valid_b, busy_b, done_b;
  logic [DW-1:0] seed_b, data_b, lstate_b = '0;
  logic [CW-1:0] cnt_b;

  lfsr_stream_ctrl #(.DATA_W(DW), .CNT_W(CW), .SHIFTS_PER_WORD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .seed_in(seed_in), .num_words(num_words),
    .lfsr_set(set_a), .lfsr_shift(shift_a), .lfsr_seed(seed_a), .lfsr_state(lstate_a),
    .m_data(data_a), .m_valid(valid_a), .m_ready(m_ready), .busy(busy_a), .done(done_a),
    .word_cnt(cnt_a));

  lfsr_stream_ctrl #(.DATA_W(DW), .CNT_W(CW), .SHIFTS_PER_WORD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .seed_in(seed_in), .num_words(num_words),
    .lfsr_set(set_b), .lfsr_shift(shift_b), .lfsr_seed(seed_b), .lfsr_state(lstate_b),
    .m_data(data_b), .m_valid(valid_b), .m_ready(m_ready), .busy(busy_b), .done(done_b),
    .word_cnt(cnt_b));

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {^(s & POLY), s[31:1]};
  endfunction

  function automatic logic [31:0] lfsr_steps(input logic [31:0] s, input int n);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = lfsr_step(r);
    return r;
  endfunction

  // Attached LFSRs.
  always @(posedge clk) begin
    if (set_a) lstate_a <= seed_a;
    else if (shift_a) lstate_a <= lfsr_step(lstate_a);
    if (set_b) lstate_b <= seed_b;
    else if (shift_b) lstate_b <= lfsr_step(lstate_b);
  end

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [15:0] done_a_q[$];
  logic [15:0] done_b_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    fails++;
    $display("FAIL %s: unexpected event, value 0x%0h, expected none", name, act);
  endtask

  // Monitor for instance A: word/done scoreboard, stall stability, set/shift exclusivity.
  initial begin
    logic        stall = 1'b0;
    logic [31:0] stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("a_stall_valid", valid_a, 1);
          check("a_stall_data", data_a, stall_data);
        end
        if (set_a || shift_a) check("a_set_shift_excl", set_a & shift_a, 0);
        if (valid_a && m_ready) begin
          if (exp_a.size() == 0) unexpected("a_word", data_a);
          else check("a_word", data_a, exp_a.pop_front());
        end
        if (done_a) begin
          if (done_a_q.size() == 0) unexpected("a_done", cnt_a);
          else check("a_done_cnt", cnt_a, done_a_q.pop_front());
        end
        stall = valid_a && !m_ready;
        stall_data = data_a;
      end
    end
  end

  // Monitor for instance B: scoreboard plus length of every shift burst.
  int shift_bursts_b = 0;
  initial begin
    int run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
      end else begin
        if (set_b || shift_b) check("b_set_shift_excl", set_b & shift_b, 0);
        if (shift_b) begin
          run++;
        end else if (run != 0) begin
          check("b_shift_burst_len", run, 4);
          shift_bursts_b++;
          run = 0;
        end
        if (valid_b && m_ready) begin
          if (exp_b.size() == 0) unexpected("b_word", data_b);
          else check("b_word", data_b, exp_b.pop_front());
        end
        if (done_b) begin
          if (done_b_q.size() == 0) unexpected("b_done", cnt_b);
          else check("b_done_cnt", cnt_b, done_b_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_set"}, set_a, 0);
    check({tag, "_shift"}, shift_a, 0);
    check({tag, "_seed"}, seed_a, 0);
    check({tag, "_data"}, data_a, 0);
    check({tag, "_valid"}, valid_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_cnt"}, cnt_a, 0);
  endtask

  // Issue a start, check LOAD-cycle seed and count clear, then measure latency to m_valid.
  task automatic start_run(input bit sel_b, input logic [31:0] seed, input logic [15:0] n,
                           input logic [31:0] exp_seed, input int exp_lat);
    int cyc;
    seed_in = seed;
    num_words = n;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    start_b = 1'b0;
    check("load_set", sel_b ? set_b : set_a, 1);
    check("load_seed", sel_b ? seed_b : seed_a, exp_seed);
    check("start_clears_cnt", sel_b ? cnt_b : cnt_a, 0);
    cyc = 1;
    while (!(sel_b ? valid_b : valid_a) && cyc < 50) begin
      tick(1);
      cyc++;
    end
    check("first_valid_latency", cyc, exp_lat);
  endtask

  task automatic wait_idle(input bit sel_b);
    int cyc = 0;
    while ((sel_b ? busy_b : busy_a) && cyc < 200) begin
      tick(1);
      cyc++;
    end
    if (cyc >= 200) unexpected("wait_idle_timeout", cyc);
    tick(1);
  endtask

  initial begin
    logic [31:0] zs;
    int wcyc;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] zseed;
    int wcyc;
    tick(3);
    check_reset_a("reset");
    check("reset_b_busy", busy_b, 0);
    check("reset_b_valid", valid_b, 0);
    rst_n = 1'b1;
    tick(1);

    // Scenario 1: seed 1, two words.
    exp_a.push_back(32'h8000_0000);
    exp_a.push_back(32'hC000_0000);
    done_a_q.push_back(16'd2);
    start_run(1'b0, 32'h1, 16'd2, 32'h1, 4);
    wait_idle(1'b0);
    tick(3);
    check("s1_cnt_hold", cnt_a, 2);

    // Scenario 2: zero words.
    done_a_q.push_back(16'd0);
    seed_in = 32'h5;
    num_words = 16'd0;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    check("s2_done", done_a, 1);
    check("s2_no_set_shift", {set_a, shift_a}, 0);
    check("s2_cnt", cnt_a, 0);
    tick(1);
    check("s2_done_one_cycle", done_a, 0);
    check("s2_idle_no_set_shift", {set_a, shift_a}, 0);

    // Scenario 3: back-pressure on the first word for 5 cycles.
    m_ready = 1'b0;
    exp_a.push_back(lfsr_steps(32'h1234_5678, 1));
    exp_a.push_back(lfsr_steps(32'h1234_5678, 2));
    done_a_q.push_back(16'd2);
    start_run(1'b0, 32'h1234_5678, 16'd2, 32'h1234_5678, 4);
    tick(5);
    check("s3_still_valid", valid_a, 1);
    check("s3_no_count_while_stalled", cnt_a, 0);
    m_ready = 1'b1;
    tick(1);
    check("s3_one_word_counted", cnt_a, 1);
    wait_idle(1'b0);

    // Scenario 4: reset during SHIFT of word 3 of 4.
    for (int i = 1; i <= 4; i++) exp_a.push_back(lfsr_steps(32'hDEAD_BEEF, i));
    start_run(1'b0, 32'hDEAD_BEEF, 16'd4, 32'hDEAD_BEEF, 4);
    wcyc = 0;
    while (!(cnt_a == 16'd2 && shift_a) && wcyc < 50) begin
      tick(1);
      wcyc++;
    end
    check("s4_in_shift_word3", {cnt_a, shift_a}, {16'd2, 1'b1});
    rst_n = 1'b0;
    tick(1);
    check_reset_a("s4_reset");
    exp_a.delete();
    rst_n = 1'b1;
    tick(10);
    check("s4_still_idle", busy_a, 0);

    // Scenario 5: zero seed.
`ifdef LFSR_STREAM_CTRL_ZERO_SEED_GUARD_EN
    zseed = 32'h0000_0001;
`else
    zseed = 32'h0000_0000;
`endif
    exp_a.push_back(lfsr_step(zseed));
    done_a_q.push_back(16'd1);
    start_run(1'b0, 32'h0, 16'd1, zseed, 4);
    wait_idle(1'b0);

    // Scenario 6: four shifts per word, second start while busy is ignored.
    for (int i = 1; i <= 3; i++) exp_b.push_back(lfsr_steps(32'hACE1_0001, 4 * i));
    done_b_q.push_back(16'd3);
    start_run(1'b1, 32'hACE1_0001, 16'd3, 32'hACE1_0001, 7);
    seed_in = 32'h0000_FFFF;
    num_words = 16'd9;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    check("s6_seed_unchanged", seed_b, 32'hACE1_0001);
    wait_idle(1'b1);
    check("s6_shift_bursts", shift_bursts_b, 3);
    check("s6_final_cnt", cnt_b, 3);

    tick(3);
    check("a_words_drained", exp_a.size(), 0);
    check("b_words_drained", exp_b.size(), 0);
    check("a_dones_drained", done_a_q.size(), 0);
    check("b_dones_drained", done_b_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
